// File: rtl/uart_prog_loader_pkg.sv
// Shared constants and state encodings for the UART program loader.
package uart_prog_loader_pkg;

    localparam logic [7:0] CMD_IMEM = 8'h01;
    localparam logic [7:0] CMD_DMEM = 8'h02;
    localparam logic [7:0] CMD_DONE = 8'hFF;

    localparam int TGT_BIT = 14;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CNT0,
        ST_CNT1,
        ST_DATA,
        ST_DONE
    } parse_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_prog_loader_if.sv
// Write port from the loader into program ROM / data RAM.
interface uart_prog_loader_if;
    logic        upg_wen_o;
    logic [14:0] upg_adr_o;
    logic [31:0] upg_dat_o;
    logic        upg_done_o;
    logic        upg_err_o;

    modport master (
        output upg_wen_o,
        output upg_adr_o,
        output upg_dat_o,
        output upg_done_o,
        output upg_err_o
    );

    modport slave (
        input upg_wen_o,
        input upg_adr_o,
        input upg_dat_o,
        input upg_done_o,
        input upg_err_o
    );
endinterface

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling with a down-counter.
// state    | meaning
// RX_IDLE  | waiting for a falling edge on the synchronized line
// RX_START | counting to mid start bit; high there means glitch
// RX_DATA  | sampling 8 data bits LSB-first every DIV cycles
// RX_STOP  | sampling stop bit; emits byte_valid_o or frame_err_o
module uart_rx_8n1
    import uart_prog_loader_pkg::*;
#(
    parameter int DIV = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       frame_err_o
);

    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(DIV - 1);

    rx_state_t     state;
    logic [1:0]    sync;
    logic          rx_prev;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= RX_IDLE;
            sync         <= 2'b11;
            rx_prev      <= 1'b1;
            cnt          <= '0;
            bit_cnt      <= '0;
            shift        <= '0;
            byte_o       <= '0;
            byte_valid_o <= 1'b0;
            frame_err_o  <= 1'b0;
        end else begin
            sync         <= {sync[0], rx};
            rx_prev      <= sync[1];
            byte_valid_o <= 1'b0;
            frame_err_o  <= 1'b0;
            case (state)
                RX_IDLE: begin
                    if (rx_prev && !sync[1]) begin
                        state <= RX_START;
                        cnt   <= HALF_M1;
                    end
                end
                RX_START: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else if (sync[1]) begin
                        state <= RX_IDLE;
                    end else begin
                        state   <= RX_DATA;
                        cnt     <= FULL_M1;
                        bit_cnt <= '0;
                    end
                end
                RX_DATA: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        shift   <= {sync[1], shift[7:1]};
                        cnt     <= FULL_M1;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7)
                            state <= RX_STOP;
                    end
                end
                RX_STOP: begin
                    // Returning to idle at the stop mid-sample lets the next start edge in.
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        state <= RX_IDLE;
                        if (sync[1]) begin
                            byte_o       <= shift;
                            byte_valid_o <= 1'b1;
                        end else begin
                            frame_err_o <= 1'b1;
                        end
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_prog_loader.sv
// UART boot loader: parses CMD/CNT/DATA sections and emits 32-bit word writes.
// state   | meaning
// ST_IDLE | expecting a command byte
// ST_CNT0 | expecting word count low byte
// ST_CNT1 | expecting word count high byte
// ST_DATA | assembling little-endian words and writing them
// ST_DONE | download complete; all further bytes ignored
module uart_prog_loader
    import uart_prog_loader_pkg::*;
#(
    parameter int CLK_FREQ = 10_000_000,
    parameter int BAUD     = 128_000
) (
    input  logic                  upg_clk_i,
    input  logic                  upg_rst_i,
    input  logic                  rx_i,
    uart_prog_loader_if.master    upg
);

    localparam int DIV = CLK_FREQ / BAUD;

    logic [7:0]   rx_byte;
    logic         rx_valid;
    logic         rx_ferr;

    parse_state_t state;
    logic         target;
    logic [13:0]  addr;
    logic [15:0]  remaining;
    logic [7:0]   cnt_lo;
    logic [1:0]   lane;
    logic [23:0]  word;

    uart_rx_8n1 #(.DIV(DIV)) u_rx (
        .clk          (upg_clk_i),
        .rst          (upg_rst_i),
        .rx           (rx_i),
        .byte_o       (rx_byte),
        .byte_valid_o (rx_valid),
        .frame_err_o  (rx_ferr)
    );

    always_ff @(posedge upg_clk_i or posedge upg_rst_i) begin
        if (upg_rst_i) begin
            state          <= ST_IDLE;
            target         <= 1'b0;
            addr           <= '0;
            remaining      <= '0;
            cnt_lo         <= '0;
            lane           <= '0;
            word           <= '0;
            upg.upg_wen_o  <= 1'b0;
            upg.upg_adr_o  <= '0;
            upg.upg_dat_o  <= '0;
            upg.upg_done_o <= 1'b0;
            upg.upg_err_o  <= 1'b0;
        end else begin
            upg.upg_wen_o <= 1'b0;
            if (rx_ferr)
                upg.upg_err_o <= 1'b1;

            // Bookkeeping trails the strobe by design so the write uses the pre-increment address.
            if (upg.upg_wen_o) begin
                addr      <= addr + 14'd1;
                remaining <= remaining - 16'd1;
                if (remaining == 16'd1)
                    state <= ST_IDLE;
            end

            if (rx_valid) begin
                case (state)
                    ST_IDLE: begin
                        if (rx_byte == CMD_IMEM || rx_byte == CMD_DMEM) begin
                            target <= (rx_byte == CMD_DMEM);
                            addr   <= '0;
                            lane   <= '0;
                            state  <= ST_CNT0;
                        end else if (rx_byte == CMD_DONE) begin
                            upg.upg_done_o <= 1'b1;
                            state          <= ST_DONE;
                        end else begin
                            upg.upg_err_o <= 1'b1;
                        end
                    end
                    ST_CNT0: begin
                        cnt_lo <= rx_byte;
                        state  <= ST_CNT1;
                    end
                    ST_CNT1: begin
                        remaining <= {rx_byte, cnt_lo};
                        lane      <= '0;
                        state     <= ({rx_byte, cnt_lo} == 16'd0) ? ST_IDLE : ST_DATA;
                    end
                    ST_DATA: begin
                        if (lane == 2'd3) begin
                            upg.upg_wen_o <= 1'b1;
                            upg.upg_adr_o <= {target, addr};
                            upg.upg_dat_o <= {rx_byte, word};
                            lane          <= '0;
                        end else begin
                            word <= {rx_byte, word[23:8]};
                            lane <= lane + 2'd1;
                        end
                    end
                    ST_DONE: ;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/uart_prog_loader.md
# uart_prog_loader

UART boot loader that sits directly upstream of instruction fetch and data memory: receives a framed 8N1 byte stream from the host PC and produces the `upg_*` write port that drives the program ROM and data RAM while the CPU is held in programming mode. It assembles little-endian 32-bit words, issues one write strobe per word with a word address, and raises a sticky done flag once the host signals end of download.

## Interface
- `CLK_FREQ`, default 10_000_000: `upg_clk_i` frequency in Hz.
- `BAUD`, default 128_000: UART bit rate. `DIV = CLK_FREQ/BAUD` (integer, ≥4).
- `upg_clk_i`  in  1  loader clock; the only clock.
- `upg_rst_i`  in  1  asynchronous, active-high reset.
- `rx_i`  in  1  UART line, idle high, asynchronous to `upg_clk_i`.
- `upg_wen_o`  out  1  one-cycle write strobe per assembled word.
- `upg_adr_o`  out  15  bit14 = target (0 imem, 1 dmem); [13:0] = word address.
- `upg_dat_o`  out  32  write data, valid while `upg_wen_o` = 1.
- `upg_done_o`  out  1  sticky: download complete.
- `upg_err_o`  out  1  sticky: framing error or unknown command seen.

## Operation
- RX front end: `rx_i` passes through a 2-flop synchronizer (both flops reset to 1). Start is detected on a falling edge. Sample at DIV/2 to confirm the start bit; a high sample there is a glitch, so return to idle. Then sample 8 data bits LSB-first, one every DIV cycles, then the stop bit. Stop = 1 gives a 1-cycle `byte_valid`. Stop = 0 drops the byte and sets `err`.
- Protocol, repeated sections:
  - CMD byte: 0x01 = imem, 0x02 = dmem, 0xFF = done.
  - For 0x01/0x02: CNT_LO, CNT_HI give N words (16-bit), followed by 4·N data bytes, little-endian within each word.
- Parser FSM states:
  - IDLE: CMD 0x01/0x02 latches the target and clears the address to 0, then goes to CNT0. CMD 0xFF sets done and goes to DONE. Any other byte sets err and stays in IDLE.
  - CNT0 → CNT1: latch N; if N = 0, return to IDLE with no writes, else go to DATA.
  - DATA: shift bytes into the word at byte lane 0..3. After lane 3, pulse `upg_wen_o`, address increments (wraps 16383 → 0), remaining count decrements, and at 0 return to IDLE.
  - DONE: ignores all further bytes; `upg_done_o` held at 1.
- No handshake with the consumer: the sink must accept a write on every `upg_wen_o` cycle.

## Timing
- Reset values: `upg_wen_o`=0, `upg_adr_o`=0, `upg_dat_o`=0, `upg_done_o`=0, `upg_err_o`=0, FSM=IDLE, RX=idle.
- `byte_valid` fires at the stop-bit mid-sample: 2 (sync) + DIV/2 + 9·DIV cycles after the start edge.
- `upg_wen_o` is registered and asserts the cycle after the `byte_valid` of lane 3. `upg_adr_o`/`upg_dat_o` are stable in that cycle and hold until the next write.
- Address/count update on the cycle `upg_wen_o` is high. The next write therefore uses address+1.
- Reset asserted mid-byte or mid-section returns everything to its reset value immediately (async). A partial word is discarded and never written.
- A new start edge is accepted no earlier than the stop-bit sample of the previous byte, so back-to-back bytes at full line rate must be received without loss.

## Structure
- Shared package: command constants (CMD_IMEM=8'h01, CMD_DMEM=8'h02, CMD_DONE=8'hFF), parser state enum, target-select bit index (14).
- One sub-module: `uart_rx_8n1` (synchronizer, bit timing, `byte_o`/`byte_valid_o`/`frame_err_o`), parameterized by DIV.
- The parser FSM and word assembler live in `uart_prog_loader`.

## Test plan
Bench settings: CLK_FREQ=1_000_000, BAUD=100_000 (DIV=10).
- Send 01 02 00 78 56 34 12 EF BE AD DE FF. Expect two writes: adr 0x0000 dat 0x12345678, then adr 0x0001 dat 0xDEADBEEF. `upg_done_o`=1, `upg_err_o`=0.
- Send 02 01 00 04 03 02 01. Expect one write: adr 0x4000 dat 0x01020304. Done stays 0.
- Send 01 00 00 then 01 01 00 AA BB CC DD. The first section produces no write. The second writes adr 0x0000 dat 0xDDCCBBAA.
- Send a byte 0x55 with stop bit forced 0, then 7E as CMD. Expect `upg_err_o`=1 sticky, no writes, FSM in IDLE.
- Send 01 02 00 11 22 and pulse `upg_rst_i` for 1 cycle. Expect outputs at reset values within the same cycle and no write. Then send 01 01 00 01 00 00 00, expecting adr 0x0000 dat 0x00000001.
- Send FF followed by 01 01 00 01 02 03 04. Expect no writes after done, with `upg_done_o` held at 1.
